// File: rtl/port_responder.sv
// CPU I/O port endpoint: a TX FIFO from CPU writes to a valid/ready device stream,
// and an RX FIFO from the device stream whose head is presented to the CPU.
module port_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_write,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cpu_read,
  output logic [DATA_WIDTH-1:0] dev_out_data,
  output logic                  dev_out_valid,
  input  logic                  dev_out_ready,
  input  logic [DATA_WIDTH-1:0] dev_in_data,
  input  logic                  dev_in_valid,
  output logic                  dev_in_ready,
  output logic [CNT_W-1:0]      tx_count,
  output logic [CNT_W-1:0]      rx_count,
  output logic                  tx_overflow,
  output logic                  rx_underflow,
  input  logic                  clear_flags
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FullCnt = cnt_t'(DEPTH);

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];

  ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  cnt_t tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic tx_overflow_q, tx_overflow_d, rx_underflow_q, rx_underflow_d;
  logic rx_ready_q, rx_ready_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_drop, rx_starve;

  // Full/empty always judged on the pre-edge registered counts.
  always_comb begin
    tx_full   = (tx_count_q == FullCnt);
    tx_empty  = (tx_count_q == '0);
    rx_full   = (rx_count_q == FullCnt);
    rx_empty  = (rx_count_q == '0);
    tx_push   = cpu_write && !tx_full;
    tx_drop   = cpu_write && tx_full;
    tx_pop    = !tx_empty && dev_out_ready;
    rx_push   = dev_in_valid && rx_ready_q;
    rx_pop    = cpu_read && !rx_empty;
    rx_starve = cpu_read && rx_empty;
  end

  always_comb begin
    tx_wptr_d  = tx_push ? tx_wptr_q + ptr_t'(1) : tx_wptr_q;
    tx_rptr_d  = tx_pop  ? tx_rptr_q + ptr_t'(1) : tx_rptr_q;
    rx_wptr_d  = rx_push ? rx_wptr_q + ptr_t'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + ptr_t'(1) : rx_rptr_q;
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop) tx_count_d = tx_count_q + cnt_t'(1);
    if (!tx_push && tx_pop) tx_count_d = tx_count_q - cnt_t'(1);
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop) rx_count_d = rx_count_q + cnt_t'(1);
    if (!rx_push && rx_pop) rx_count_d = rx_count_q - cnt_t'(1);
    rx_ready_d = (rx_count_d != FullCnt);
    // A new trigger takes priority over clear_flags on the same edge.
    tx_overflow_d  = tx_drop   ? 1'b1 : (clear_flags ? 1'b0 : tx_overflow_q);
    rx_underflow_d = rx_starve ? 1'b1 : (clear_flags ? 1'b0 : rx_underflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q      <= '0;
      tx_rptr_q      <= '0;
      rx_wptr_q      <= '0;
      rx_rptr_q      <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      rx_ready_q     <= 1'b0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      tx_wptr_q      <= tx_wptr_d;
      tx_rptr_q      <= tx_rptr_d;
      rx_wptr_q      <= rx_wptr_d;
      rx_rptr_q      <= rx_rptr_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      rx_ready_q     <= rx_ready_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

  // Storage is not reset; outputs are gated by the counts instead.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= cpu_wdata;
    if (rx_push) rx_mem[rx_wptr_q] <= dev_in_data;
  end

  always_comb begin
    dev_out_valid = !tx_empty;
    dev_out_data  = tx_empty ? '0 : tx_mem[tx_rptr_q];
    cpu_rdata     = rx_empty ? '0 : rx_mem[rx_rptr_q];
    dev_in_ready  = rx_ready_q;
    tx_count      = tx_count_q;
    rx_count      = rx_count_q;
    tx_overflow   = tx_overflow_q;
    rx_underflow  = rx_underflow_q;
  end

endmodule

// File: tb/tb_port_responder.sv
// Directed bench for port_responder: inputs change 1 time unit after posedge,
// outputs are checked before the following edge.
module tb_port_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_wdata, cpu_rdata, dev_out_data, dev_in_data;
  logic        cpu_write, cpu_read, dev_out_valid, dev_out_ready;
  logic        dev_in_valid, dev_in_ready, tx_overflow, rx_underflow, clear_flags;
  logic [2:0]  tx_count, rx_count;

  int n_tests = 0;
  int n_fail  = 0;

  port_responder #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_wdata    (cpu_wdata),
    .cpu_write    (cpu_write),
    .cpu_rdata    (cpu_rdata),
    .cpu_read     (cpu_read),
    .dev_out_data (dev_out_data),
    .dev_out_valid(dev_out_valid),
    .dev_out_ready(dev_out_ready),
    .dev_in_data  (dev_in_data),
    .dev_in_valid (dev_in_valid),
    .dev_in_ready (dev_in_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .tx_overflow  (tx_overflow),
    .rx_underflow (rx_underflow),
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_wdata = '0; cpu_write = 1'b0; cpu_read = 1'b0;
    dev_out_ready = 1'b0; dev_in_data = '0; dev_in_valid = 1'b0; clear_flags = 1'b0;
    #12;
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_out_valid", 32'(dev_out_valid), 0);
    chk("rst_in_ready", 32'(dev_in_ready), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_out_data", 32'(dev_out_data), 0);
    chk("rst_flags", {30'd0, tx_overflow, rx_underflow}, 0);
    tick();
    rst_n = 1'b1;
    chk("rel_ready_before_edge", 32'(dev_in_ready), 0);
    tick();
    chk("rel_ready_after_edge", 32'(dev_in_ready), 1);

    // Single TX word held while device stalls, then popped.
    cpu_wdata = 16'h1234; cpu_write = 1'b1;
    tick();
    cpu_write = 1'b0;
    chk("tx1_valid", 32'(dev_out_valid), 1);
    chk("tx1_data", 32'(dev_out_data), 32'h1234);
    chk("tx1_count", 32'(tx_count), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tx1_hold", 32'(dev_out_data), 32'h1234);
    end
    dev_out_ready = 1'b1;
    tick();
    dev_out_ready = 1'b0;
    chk("tx1_pop_count", 32'(tx_count), 0);
    chk("tx1_pop_valid", 32'(dev_out_valid), 0);
    chk("tx1_pop_data", 32'(dev_out_data), 0);

    // Overflow: fifth write into a 4-deep FIFO is dropped.
    for (int i = 1; i <= 5; i++) begin
      cpu_wdata = 16'hA000 + 16'(i); cpu_write = 1'b1;
      tick();
    end
    cpu_write = 1'b0;
    chk("ovf_count", 32'(tx_count), 4);
    chk("ovf_flag", 32'(tx_overflow), 1);
    dev_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_data", 32'(dev_out_data), 32'hA001 + 32'(k));
      tick();
    end
    dev_out_ready = 1'b0;
    chk("ovf_drained_valid", 32'(dev_out_valid), 0);
    chk("ovf_flag_sticky", 32'(tx_overflow), 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("ovf_cleared", 32'(tx_overflow), 0);

    // Full TX with write and device pop on the same edge: write dropped, count drops.
    for (int i = 1; i <= 4; i++) begin
      cpu_wdata = 16'hB000 + 16'(i); cpu_write = 1'b1;
      tick();
    end
    cpu_wdata = 16'h5555; dev_out_ready = 1'b1; clear_flags = 1'b1;
    tick();
    cpu_write = 1'b0; clear_flags = 1'b0;
    chk("fullpop_count", 32'(tx_count), 3);
    chk("fullpop_ovf_set_wins", 32'(tx_overflow), 1);
    for (int k = 0; k < 3; k++) begin
      chk("fullpop_drain", 32'(dev_out_data), 32'hB002 + 32'(k));
      tick();
    end
    dev_out_ready = 1'b0;
    chk("fullpop_empty", 32'(dev_out_valid), 0);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;

    // RX path.
    dev_in_valid = 1'b1; dev_in_data = 16'h00FF;
    tick();
    dev_in_data = 16'h0F0F;
    tick();
    dev_in_valid = 1'b0;
    chk("rx_head", 32'(cpu_rdata), 32'h00FF);
    chk("rx_count2", 32'(rx_count), 2);
    cpu_read = 1'b1;
    tick();
    chk("rx_pop1", 32'(cpu_rdata), 32'h0F0F);
    chk("rx_pop1_count", 32'(rx_count), 1);
    tick();
    cpu_read = 1'b0;
    chk("rx_pop2", 32'(cpu_rdata), 0);
    chk("rx_pop2_count", 32'(rx_count), 0);
    chk("rx_no_underflow", 32'(rx_underflow), 0);

    // Underflow read concurrent with a device push.
    cpu_read = 1'b1; dev_in_valid = 1'b1; dev_in_data = 16'hBEEF;
    tick();
    cpu_read = 1'b0; dev_in_valid = 1'b0;
    chk("unf_flag", 32'(rx_underflow), 1);
    chk("unf_count", 32'(rx_count), 1);
    chk("unf_rdata", 32'(cpu_rdata), 32'hBEEF);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("unf_cleared", 32'(rx_underflow), 0);
    cpu_read = 1'b1;
    tick();
    cpu_read = 1'b0;
    chk("unf_drained", 32'(rx_count), 0);

    // Wrap-around with occupancy held at 2.
    dev_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dev_in_data = 16'hC000 + 16'(i);
      tick();
    end
    cpu_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dev_in_data = 16'hC002 + 16'(i);
      chk("wrap_head", 32'(cpu_rdata), 32'hC000 + 32'(i));
      tick();
      chk("wrap_count", 32'(rx_count), 2);
    end
    cpu_read = 1'b0;

    // Fill RX: ready drops and further device words are ignored.
    for (int i = 0; i < 2; i++) begin
      dev_in_data = 16'hD000 + 16'(i);
      tick();
    end
    chk("full_count", 32'(rx_count), 4);
    chk("full_ready", 32'(dev_in_ready), 0);
    dev_in_data = 16'hDEAD;
    tick();
    dev_in_valid = 1'b0;
    chk("full_ignored_count", 32'(rx_count), 4);
    cpu_read = 1'b1;
    chk("full_rd0", 32'(cpu_rdata), 32'hC00A);
    tick();
    chk("full_ready_back", 32'(dev_in_ready), 1);
    chk("full_rd1", 32'(cpu_rdata), 32'hC00B);
    tick();
    chk("full_rd2", 32'(cpu_rdata), 32'hD000);
    tick();
    chk("full_rd3", 32'(cpu_rdata), 32'hD001);
    tick();
    cpu_read = 1'b0;
    chk("full_rd_empty", 32'(cpu_rdata), 0);
    chk("full_rd_count", 32'(rx_count), 0);

    // Asynchronous reset mid-stream.
    cpu_write = 1'b1; dev_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_wdata = 16'hE001 + 16'(i);
      dev_in_data = 16'hF001 + 16'(i);
      if (i == 2) dev_in_valid = 1'b0;
      tick();
    end
    cpu_write = 1'b0; dev_in_valid = 1'b0;
    chk("mid_tx_count", 32'(tx_count), 3);
    chk("mid_rx_count", 32'(rx_count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_count", 32'(tx_count), 0);
    chk("arst_rx_count", 32'(rx_count), 0);
    chk("arst_out_valid", 32'(dev_out_valid), 0);
    chk("arst_out_data", 32'(dev_out_data), 0);
    chk("arst_rdata", 32'(cpu_rdata), 0);
    chk("arst_in_ready", 32'(dev_in_ready), 0);
    tick();
    rst_n = 1'b1;
    chk("arst_rel_ready_before", 32'(dev_in_ready), 0);
    tick();
    chk("arst_rel_ready_after", 32'(dev_in_ready), 1);
    chk("arst_rel_out_data", 32'(dev_out_data), 0);
    chk("arst_rel_rdata", 32'(cpu_rdata), 0);
    chk("arst_rel_tx_count", 32'(tx_count), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
